// File: rtl/oled_pixel_streamer_pkg.sv
// oled_pkg: shared panel geometry, command bytes, FSM states and RGB565 colours.
package oled_pkg;
  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;
  localparam logic [7:0] CMD_SET_COL = 8'h15;
  localparam logic [7:0] CMD_SET_ROW = 8'h75;
  typedef enum logic [1:0] {IDLE, CMD, PIXEL, GAP} state_e;
  localparam logic [15:0] RGB_BLACK  = 16'h0000;
  localparam logic [15:0] RGB_WHITE  = 16'hFFFF;
  localparam logic [15:0] RGB_RED    = 16'hF800;
  localparam logic [15:0] RGB_GREEN  = 16'h07E0;
  localparam logic [15:0] RGB_BLUE   = 16'h001F;
  localparam logic [15:0] RGB_YELLOW = 16'hFFE0;
  // Window-set sequence: col cmd, 0, last col, row cmd, 0, last row.
  function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [7:0] w1, input logic [7:0] h1);
    return idx == 3'd0 ? CMD_SET_COL : idx == 3'd2 ? w1 : idx == 3'd3 ? CMD_SET_ROW : idx == 3'd5 ? h1 : 8'h00;
  endfunction
endpackage

// File: rtl/oled_pixel_streamer_shifter.sv
// oled_spi_shifter: mode-0 SPI serializer for 8- or 16-bit words, MSB first.
module oled_spi_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] word_i,
  input  logic        wide_i,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        done_o
);
  localparam int PER = 2 * CLK_DIV;
  localparam int CW  = $clog2(PER);
  logic [CW-1:0] cnt_q;
  logic [3:0]    left_q;
  logic [15:0]   sh_q;
  logic          act_q, sclk_q, mosi_q, last_ph;
  assign last_ph = cnt_q == CW'(PER - 1);
  assign done_o  = act_q && last_ph && left_q == 4'd0;
  assign sclk_o  = sclk_q;
  assign mosi_o  = mosi_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      left_q <= '0;
      sh_q   <= '0;
      act_q  <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
    end else if (load_i) begin
      sh_q   <= word_i;
      left_q <= wide_i ? 4'd15 : 4'd7;
      cnt_q  <= '0;
      act_q  <= 1'b1;
      sclk_q <= 1'b0;
      mosi_q <= word_i[15];
    end else if (act_q && last_ph) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
      act_q  <= left_q != 4'd0;
      mosi_q <= left_q != 4'd0 && sh_q[14];
      sh_q   <= sh_q << 1;
      left_q <= left_q - 4'd1;
    end else if (act_q) begin
      cnt_q  <= cnt_q + 1'b1;
      sclk_q <= int'(cnt_q) + 1 >= CLK_DIV;
    end
  end
endmodule

// File: rtl/oled_pixel_streamer.sv
// oled_pixel_streamer: raster-scans a combinational renderer and streams frames to a 96x64 SPI OLED.
module oled_pixel_streamer
  import oled_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int WIDTH      = OLED_WIDTH,
  parameter int HEIGHT     = OLED_HEIGHT,
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] oled_data,
  output logic [6:0]  x,
  output logic [5:0]  y,
  output logic [12:0] pixel_index,
  output logic        frame_begin,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic        dc
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [7:0] W1 = 8'(WIDTH - 1);
  localparam logic [7:0] H1 = 8'(HEIGHT - 1);
  state_e          state_q;
  logic [2:0]      idx_q;
  logic [GW-1:0]   gap_q;
  logic [6:0]      x_q;
  logic [5:0]      y_q;
  logic [12:0]     pix_q;
  logic            last_q, cs_n_q, dc_q, busy_q, fb_q;
  logic            done, load, ld_cmd0, ld_cmd, ld_pix, gap_end, last_x, at_end;
  logic [15:0]     word;
  oled_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .word_i (word),
    .wide_i (ld_pix),
    .sclk_o (sclk),
    .mosi_o (mosi),
    .done_o (done)
  );
  // Loads land on the edge right after the shifter's last cycle, so bits run back-to-back.
  always_comb begin
    gap_end = state_q == GAP && gap_q == GW'(GAP_CYCLES - 1);
    last_x  = x_q == 7'(WIDTH - 1);
    at_end  = last_x && y_q == 6'(HEIGHT - 1);
    ld_cmd0 = enable && (state_q == IDLE || gap_end);
    ld_cmd  = state_q == CMD && done && idx_q != 3'd5;
    ld_pix  = done && (state_q == CMD ? idx_q == 3'd5 : state_q == PIXEL && !last_q);
    load    = ld_cmd0 || ld_cmd || ld_pix;
    word    = ld_pix ? oled_data : {cmd_byte(ld_cmd0 ? 3'd0 : idx_q + 3'd1, W1, H1), 8'h00};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pix_q   <= '0;
      last_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      dc_q    <= 1'b0;
      busy_q  <= 1'b0;
      fb_q    <= 1'b0;
    end else begin
      fb_q <= 1'b0;
      if (ld_pix) begin
        x_q    <= last_x ? 7'd0 : x_q + 7'd1;
        y_q    <= at_end ? 6'd0 : last_x ? y_q + 6'd1 : y_q;
        pix_q  <= at_end ? 13'd0 : pix_q + 13'd1;
        last_q <= at_end;
      end
      case (state_q)
        IDLE: if (enable) begin
          state_q <= CMD;
          cs_n_q  <= 1'b0;
          busy_q  <= 1'b1;
          idx_q   <= '0;
        end
        CMD: if (done) begin
          if (idx_q == 3'd5) begin
            state_q <= PIXEL;
            dc_q    <= 1'b1;
            fb_q    <= 1'b1;
          end else idx_q <= idx_q + 3'd1;
        end
        PIXEL: if (done && last_q) begin
          state_q <= GAP;
          cs_n_q  <= 1'b1;
          dc_q    <= 1'b0;
          gap_q   <= '0;
          last_q  <= 1'b0;
        end
        GAP: if (gap_end) begin
          state_q <= enable ? CMD : IDLE;
          cs_n_q  <= !enable;
          busy_q  <= enable;
          idx_q   <= '0;
        end else gap_q <= gap_q + 1'b1;
      endcase
    end
  end
  assign x           = x_q;
  assign y           = y_q;
  assign pixel_index = pix_q;
  assign frame_begin = fb_q;
  assign busy        = busy_q;
  assign cs_n        = cs_n_q;
  assign dc          = dc_q;
endmodule

// File: tb/tb_oled_pixel_streamer.sv
// tb_oled_pixel_streamer: scoreboard bench; a 4x2 instance for framing and a 96x64 CLK_DIV=1 instance.
module tb_oled_pixel_streamer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, en = 1'b0, mode = 1'b0, rst_nb = 1'b0, en_b = 1'b0;
  logic [6:0]  x_a, x_b;
  logic [5:0]  y_a, y_b;
  logic [12:0] pi_a, pi_b;
  logic        fb_a, busy_a, sclk_a, mosi_a, cs_a, dc_a;
  logic        fb_b, busy_b, sclk_b, mosi_b, cs_b, dc_b;
  logic [15:0] data_a, data_b;
  assign data_a = mode ? {x_a, 3'b000, y_a} : 16'hF800;
  assign data_b = {x_b, 3'b000, y_b};
  oled_pixel_streamer #(.CLK_DIV(2), .WIDTH(4), .HEIGHT(2), .GAP_CYCLES(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en), .oled_data(data_a), .x(x_a), .y(y_a),
    .pixel_index(pi_a), .frame_begin(fb_a), .busy(busy_a), .sclk(sclk_a), .mosi(mosi_a),
    .cs_n(cs_a), .dc(dc_a));
  oled_pixel_streamer #(.CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_nb), .enable(en_b), .oled_data(data_b), .x(x_b), .y(y_b),
    .pixel_index(pi_b), .frame_begin(fb_b), .busy(busy_b), .sclk(sclk_b), .mosi(mosi_b),
    .cs_n(cs_b), .dc(dc_b));
  localparam logic [7:0] CMD_A [6] = '{8'h15, 8'h00, 8'h03, 8'h75, 8'h00, 8'h01};
  localparam logic [7:0] CMD_B [6] = '{8'h15, 8'h00, 8'h5F, 8'h75, 8'h00, 8'h3F};
  int total = 0, bad = 0, fb_cnt = 0, cyc = 0;
  logic [16:0] qa[$], qb[$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic push_cmds(input bit to_b);
    for (int i = 0; i < 6; i++)
      if (to_b) qb.push_back({9'h000, CMD_B[i]});
      else qa.push_back({9'h000, CMD_A[i]});
  endtask
  // SPI decoders for both instances: bits taken at sclk rise, word width from dc of its first bit.
  initial begin
    logic [15:0] sh[2];
    int nb[2];
    logic dcb[2], ps[2], pm[2], pc[2], sc[2], mo[2], cs[2], dcs[2], rs[2];
    logic [16:0] got;
    nb = '{0, 0};
    ps = '{1'b0, 1'b0};
    pm = '{1'b0, 1'b0};
    pc = '{1'b1, 1'b1};
    sh = '{16'h0, 16'h0};
    dcb = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      sc = '{sclk_a, sclk_b};
      mo = '{mosi_a, mosi_b};
      cs = '{cs_a, cs_b};
      dcs = '{dc_a, dc_b};
      rs = '{rst_n, rst_nb};
      for (int d = 0; d < 2; d++) begin
        if (d == 1 && rs[1] && !cs[1] && !pc[1]) chk("b_sclk_toggle", 32'(sc[1]), 32'(!ps[1]));
        if (!rs[d] || cs[d]) nb[d] = 0;
        else if (sc[d] && !ps[d]) begin
          chk(d == 0 ? "a_mosi_at_rise" : "b_mosi_at_rise", 32'(mo[d]), 32'(pm[d]));
          if (nb[d] == 0) dcb[d] = dcs[d];
          sh[d] = {sh[d][14:0], mo[d]};
          nb[d]++;
          if (nb[d] == (dcb[d] ? 16 : 8)) begin
            got = {dcb[d], dcb[d] ? sh[d] : {8'h00, sh[d][7:0]}};
            if (d == 0 && qa.size() > 0) chk("a_word", 32'(got), 32'(qa.pop_front()));
            else if (d == 1 && qb.size() > 0) chk("b_word", 32'(got), 32'(qb.pop_front()));
            else if (d == 0) begin
              total++;
              bad++;
              $display("FAIL a_unexpected_word: got %0h with nothing expected", got);
            end
            nb[d] = 0;
          end
        end
        ps[d] = sc[d];
        pm[d] = mo[d];
        pc[d] = cs[d];
      end
    end
  end
  initial begin
    logic [6:0] pxa, pxb;
    logic [5:0] pya, pyb;
    pxa = '0; pya = '0; pxb = '0; pyb = '0;
    forever begin
      @(negedge clk);
      if (fb_a) begin
        fb_cnt++;
        chk("fb_dc", 32'(dc_a), 32'd1);
        chk("fb_pixel_index", 32'(pi_a), 32'd1);
      end
      if (x_a != pxa || y_a != pya) chk("a_pixel_index", 32'(pi_a), 32'(y_a) * 4 + 32'(x_a));
      if (x_b != pxb || y_b != pyb) chk("b_pixel_index", 32'(pi_b), 32'(y_b) * 96 + 32'(x_b));
      pxa = x_a; pya = y_a; pxb = x_b; pyb = y_b;
    end
  end
  initial begin
    int t0, t1, n;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_a), 32'd1);
    chk("rst_xy", 32'({x_a, y_a}), 32'd0);
    chk("rst_pixel_index", 32'(pi_a), 32'd0);
    chk("rst_sclk_mosi_dc", 32'({sclk_a, mosi_a, dc_a}), 32'd0);
    chk("rst_busy_fb", 32'({busy_a, fb_a}), 32'd0);
    chk("rst_b_cs_busy", 32'({cs_b, busy_b}), 32'h2);
    rst_n = 1'b1;
    rst_nb = 1'b1;
    push_cmds(1'b1);
    for (int k = 0; k < 39; k++) qb.push_back({1'b1, 7'(k), 9'h000});
    en_b = 1'b1;
    n = 0;
    while (pi_b != 13'd40 && n < 4000) begin @(negedge clk); n++; end
    chk("b_reach_pixel40", 32'(pi_b), 32'd40);
    rst_nb = 1'b0;
    @(negedge clk);
    chk("b_midrst_cs_n", 32'(cs_b), 32'd1);
    chk("b_midrst_xy", 32'({x_b, y_b}), 32'd0);
    chk("b_midrst_busy", 32'(busy_b), 32'd0);
    chk("b_midrst_sclk_mosi", 32'({sclk_b, mosi_b}), 32'd0);
    chk("b_words_seen", 32'(qb.size()), 32'd0);
    en_b = 1'b0;
    rst_nb = 1'b1;
    push_cmds(1'b0);
    for (int k = 0; k < 8; k++) qa.push_back({1'b1, 16'hF800});
    en = 1'b1;
    n = 0;
    while (cs_a && n < 10) begin @(negedge clk); n++; end
    chk("a_frame1_start", 32'(cs_a), 32'd0);
    t0 = cyc;
    n = 0;
    while (!cs_a && n < 2000) begin @(negedge clk); n++; end
    chk("a_frame1_end", 32'(cs_a), 32'd1);
    mode = 1'b1;
    push_cmds(1'b0);
    for (int k = 0; k < 8; k++) qa.push_back({1'b1, 7'(k % 4), 3'b000, 6'(k / 4)});
    n = 0;
    while (cs_a && n < 100) begin n++; @(negedge clk); end
    t1 = cyc;
    chk("a_gap_cycles", 32'(n), 32'd16);
    chk("a_frame_period", 32'(t1 - t0), 32'd720);
    chk("a_fb_count_frame1", 32'(fb_cnt), 32'd1);
    chk("a_frame1_consumed", 32'(qa.size()), 32'd14);
    n = 0;
    while (x_a != 7'd3 && n < 2000) begin @(negedge clk); n++; end
    chk("a_reach_pixel3", 32'(x_a), 32'd3);
    en = 1'b0;
    n = 0;
    while (!cs_a && n < 2000) begin @(negedge clk); n++; end
    chk("a_frame2_end", 32'(cs_a), 32'd1);
    repeat (20) @(negedge clk);
    chk("a_idle_busy", 32'(busy_a), 32'd0);
    chk("a_fb_count_frame2", 32'(fb_cnt), 32'd2);
    chk("a_frame2_consumed", 32'(qa.size()), 32'd0);
    n = 0;
    repeat (100) begin @(negedge clk); if (!cs_a) n++; end
    chk("a_no_restart", 32'(n), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
